// File: rtl/uart_apb_sched.sv
// ---------------------------------------------------------------------------
// uart_apb_sched
//
// Two-requester APB master scheduler placed in front of the APB_UART slave.
// Requester 0 is the TX-side producer (data/config writes), requester 1 is
// the RX-side consumer (data/status reads). Commands are arbitrated
// round-robin, run through the APB SETUP and ACCESS phases, and completed
// with a one-cycle response pulse to the owning requester. An ACCESS phase
// that never sees PREADY is aborted after TIMEOUT cycles with rsp_err=1.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req_valid/req_write   per-requester command valid and direction (bit i)
//   req_addr/req_wdata    per-requester fields, slice i = [i*W +: W]
//   req_ready             one-hot command accept (combinational, IDLE only)
//   rsp_valid             one-hot completion pulse (registered)
//   rsp_err, rsp_rdata    timeout flag / read data of the latest response
//   PSEL..PWDATA          APB master request signals
//   PREADY, PRDATA        APB slave response signals
// ---------------------------------------------------------------------------
module uart_apb_sched #(
  parameter int ADDR_W  = 12,
  parameter int WDATA_W = 8,
  parameter int RDATA_W = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [2*ADDR_W-1:0]    req_addr,
  input  logic [2*WDATA_W-1:0]   req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_err,
  output logic [RDATA_W-1:0]     rsp_rdata,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [WDATA_W-1:0]     PWDATA,
  input  logic                   PREADY,
  input  logic [RDATA_W-1:0]     PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Index of the final ACCESS cycle before abort (counter starts at 0).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic                last_grant_reg;   // also identifies the in-flight owner
  logic [15:0]         cnt_reg;

  logic                grant_hit;
  logic                grant_idx;
  logic                accept;
  logic                access_done;
  logic                access_timeout;

  logic [ADDR_W-1:0]   addr_arr  [2];
  logic [WDATA_W-1:0]  wdata_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*WDATA_W +: WDATA_W];
    end
  endgenerate

  // Round-robin pick: a lone requester always wins; under contention the
  // one that did not win last time goes next.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 1'b0;
    case (req_valid)
      2'b01:   begin grant_hit = 1'b1; grant_idx = 1'b0;            end
      2'b10:   begin grant_hit = 1'b1; grant_idx = 1'b1;            end
      2'b11:   begin grant_hit = 1'b1; grant_idx = ~last_grant_reg; end
      default: ;
    endcase
  end

  // No handshake can complete while reset is held, so ready is masked too.
  assign accept = (state_reg == IDLE) && grant_hit && !PRESET;

  // State register. PSEL/PENABLE decode straight from it, so an async reset
  // drops them immediately without waiting for a clock edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    req_ready      = 2'b00;
    PSEL           = 1'b0;
    PENABLE        = 1'b0;
    access_done    = 1'b0;
    access_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = SETUP;
        end
      end
      SETUP: begin
        PSEL       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // PREADY takes priority over a coinciding timeout.
        if (PREADY) begin
          access_done = 1'b1;
          state_next  = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          access_timeout = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, wait counter and response registers. The response is
  // registered on the ACCESS exit edge, so it is visible during RESP.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      last_grant_reg <= 1'b1;
      PWRITE         <= 1'b0;
      PADDR          <= '0;
      PWDATA         <= '0;
      cnt_reg        <= '0;
      rsp_valid      <= 2'b00;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      if (accept) begin
        last_grant_reg <= grant_idx;
        PWRITE         <= req_write[grant_idx];
        PADDR          <= addr_arr[grant_idx];
        PWDATA         <= wdata_arr[grant_idx];
      end

      if (state_reg == ACCESS)    cnt_reg <= cnt_reg + 16'd1;
      else if (state_reg == RESP) cnt_reg <= '0;

      if (access_done || access_timeout) begin
        rsp_valid <= last_grant_reg ? 2'b10 : 2'b01;
        rsp_err   <= access_timeout;
        rsp_rdata <= (access_done && !PWRITE) ? PRDATA : '0;
      end else begin
        rsp_valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_apb_sched
//
// Scoreboard bench for uart_apb_sched (TIMEOUT=8). A driver feeds per-
// requester command queues onto the request ports; a monitor holds a
// transaction-level reference (round-robin grant, busy window, latency and
// a byte memory image) that predicts req_ready every cycle and pushes the
// expected response on each accept, then pops and compares on rsp_valid.
// A behavioural APB slave inserts the per-command wait count, keeps its own
// memory image and checks the bus phases of the transfer in flight.
// ---------------------------------------------------------------------------
module tb_uart_apb_sched;

  localparam int TMO = 8;

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          gap;   // idle cycles before asserting valid
    int          wt;    // PREADY wait cycles; >= TMO means never ready
  } cmd_t;

  typedef struct {
    int          owner;
    logic        write;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        err;
    logic [31:0] rdata;
    int          wt;
    int          acc_cyc;
    int          rsp_cyc;
  } exp_t;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [7:0]  PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  uart_apb_sched #(
    .ADDR_W (12),
    .WDATA_W(8),
    .RDATA_W(32),
    .TIMEOUT(TMO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  cmd_t cq [2][$];
  cmd_t cur [2];
  logic rv [2];
  bit   active [2];
  int   gapc [2];

  exp_t exp_q [$];
  int   last_g;
  int   busy_until;
  logic        last_err;
  logic [31:0] last_rdata;

  logic [7:0] ref_mem   [4096];
  logic [7:0] slave_mem [4096];

  assign req_valid = {rv[1], rv[0]};
  assign req_write = {cur[1].write, cur[0].write};
  assign req_addr  = {cur[1].addr, cur[0].addr};
  assign req_wdata = {cur[1].wdata, cur[0].wdata};

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic logic [7:0] mem_init(input logic [11:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] rd_word(input logic [11:0] a, input logic [7:0] m);
    return {12'h000, a, m};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  // ---------------- driver ----------------
  initial begin : driver
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; active[i] = 1'b0; gapc[i] = 0;
      cur[i] = '{default: 0};
    end
    forever begin
      @(negedge PCLK);
      for (int i = 0; i < 2; i++)
        if (active[i] && !PRESET && req_ready[i]) active[i] = 1'b0;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!active[i] && cq[i].size() > 0) begin
          if (gapc[i] < cq[i][0].gap) gapc[i]++;
          else begin
            cur[i]    = cq[i].pop_front();
            gapc[i]   = 0;
            active[i] = 1'b1;
          end
        end
        rv[i] = active[i];
      end
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  initial begin : monitor
    exp_t e;
    logic [1:0] exp_rdy;
    int g;
    bit to;
    for (int a = 0; a < 4096; a++) ref_mem[a] = mem_init(12'(a));
    last_g = 1; busy_until = -1; last_err = 1'b0; last_rdata = 32'h0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        exp_q.delete();
        last_g = 1; busy_until = -1; last_err = 1'b0; last_rdata = 32'h0;
      end else begin
        // Grant prediction: only after the previous response cycle.
        g = -1;
        if (cyc > busy_until) begin
          if (req_valid == 2'b11)  g = 1 - last_g;
          else if (req_valid[0])   g = 0;
          else if (req_valid[1])   g = 1;
        end
        exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
          e.owner = g;
          e.write = cur[g].write;
          e.addr  = cur[g].addr;
          e.wdata = cur[g].wdata;
          e.wt    = cur[g].wt;
          to      = (e.wt >= TMO);
          e.err   = to;
          e.rdata = (!e.write && !to) ? rd_word(e.addr, ref_mem[e.addr]) : 32'h0;
          if (e.write && !to) ref_mem[e.addr] = e.wdata;
          e.acc_cyc = cyc;
          e.rsp_cyc = to ? cyc + 2 + TMO : cyc + 3 + e.wt;
          exp_q.push_back(e);
          last_g = g;
          busy_until = e.rsp_cyc;
        end

        if (rsp_valid != 2'b00) begin
          chk("psel_in_resp", 32'(PSEL), 32'h0);
          if (exp_q.size() == 0) note_fail("unexpected_rsp");
          else begin
            e = exp_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), (e.owner == 0) ? 32'h1 : 32'h2);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_cycle", 32'(cyc), 32'(e.rsp_cyc));
            last_err = e.err;
            last_rdata = e.rdata;
            $display("rsp req%0d %s addr=%h wdata=%h wait=%0d err=%0d rdata=%h cyc=%0d",
                     e.owner, e.write ? "WR" : "RD", e.addr, e.wdata, e.wt,
                     rsp_err, rsp_rdata, cyc);
          end
        end else begin
          chk("rsp_err_hold", 32'(rsp_err), 32'(last_err));
          chk("rsp_rdata_hold", rsp_rdata, last_rdata);
          if (exp_q.size() > 0 && cyc > exp_q[0].rsp_cyc) begin
            note_fail("missing_rsp");
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- APB slave ----------------
  initial begin : slave
    exp_t e;
    int acc_n;
    bit prev_setup;
    bit rdy;
    for (int a = 0; a < 4096; a++) slave_mem[a] = mem_init(12'(a));
    PREADY = 1'b0; PRDATA = 32'h0; acc_n = 0; prev_setup = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE && !PRESET) begin
        if (exp_q.size() == 0) begin
          note_fail("access_without_grant");
          PREADY = 1'b1;
        end else begin
          e = exp_q[0];
          if (acc_n == 0) begin
            chk("setup_before_access", 32'(prev_setup), 32'h1);
            chk("access_start_cycle", 32'(cyc), 32'(e.acc_cyc + 2));
          end
          chk("paddr", 32'(PADDR), 32'(e.addr));
          chk("pwrite", 32'(PWRITE), 32'(e.write));
          if (e.write) chk("pwdata", 32'(PWDATA), 32'(e.wdata));
          rdy = (acc_n == e.wt);
          PREADY = rdy;
          PRDATA = rdy ? rd_word(PADDR, slave_mem[PADDR]) : $urandom;
          if (rdy && PWRITE) slave_mem[PADDR] = PWDATA;
        end
        acc_n++;
      end else begin
        acc_n  = 0;
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end
      prev_setup = PSEL && !PENABLE;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int i, input logic w, input logic [11:0] a,
                      input logic [7:0] d, input int gap, input int wt);
    cmd_t c;
    c.write = w; c.addr = a; c.wdata = d; c.gap = gap; c.wt = wt;
    cq[i].push_back(c);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((cq[0].size() > 0 || cq[1].size() > 0 || active[0] || active[1] ||
            exp_q.size() > 0) && n < bound) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    if (n >= bound) note_fail("drain_timeout");
    repeat (2) @(negedge PCLK);
  endtask

  task automatic pulse_reset();
    @(negedge PCLK);
    #2 PRESET = 1'b1;
    @(negedge PCLK);
    #2 PRESET = 1'b0;
  endtask

  initial begin : main
    int n;
    int r;
    int wt;
    logic [11:0] a;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_pwrite", 32'(PWRITE), 32'h0);
    chk("rst_paddr", 32'(PADDR), 32'h0);
    chk("rst_pwdata", 32'(PWDATA), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    #2 PRESET = 1'b0;

    // Single zero-wait write, then a 3-wait read of the same address.
    push(0, 1'b1, 12'h004, 8'hA5, 0, 0);
    drain(100);
    push(1, 1'b0, 12'h004, 8'h00, 0, 3);
    drain(100);

    // Contention from reset: grants must alternate starting with 0.
    pulse_reset();
    push(0, 1'b1, 12'h008, 8'h11, 0, 0);
    push(0, 1'b1, 12'h009, 8'h22, 0, 1);
    push(1, 1'b0, 12'h008, 8'h00, 0, 0);
    push(1, 1'b0, 12'h009, 8'h00, 0, 2);
    drain(200);

    // Timeout, PREADY on the very last ACCESS cycle, then normal traffic.
    push(0, 1'b0, 12'h00C, 8'h00, 0, TMO);
    push(0, 1'b1, 12'h00C, 8'h7E, 0, TMO - 1);
    push(0, 1'b0, 12'h00C, 8'h00, 0, 0);
    drain(200);

    // Back-to-back single requester.
    push(0, 1'b1, 12'h100, 8'h01, 0, 0);
    push(0, 1'b1, 12'h101, 8'h02, 0, 0);
    push(0, 1'b1, 12'h102, 8'h03, 0, 0);
    drain(200);

    // Reset asserted mid-ACCESS, off the clock edge.
    push(0, 1'b0, 12'h010, 8'h00, 0, 5);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(PSEL && PENABLE) && n < 50);
    if (n >= 50) note_fail("no_access_before_reset");
    #2 PRESET = 1'b1;
    #1;
    chk("async_rst_psel", 32'(PSEL), 32'h0);
    chk("async_rst_penable", 32'(PENABLE), 32'h0);
    @(negedge PCLK);
    #2 PRESET = 1'b0;
    push(0, 1'b1, 12'h020, 8'h5C, 0, 0);
    push(1, 1'b0, 12'h020, 8'h00, 0, 0);
    drain(200);

    // Randomized mixed traffic.
    for (int k = 0; k < 120; k++) begin
      r = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        9:       wt = TMO;
        8:       wt = TMO - 1;
        default: wt = int'($urandom_range(0, 3));
      endcase
      a = 12'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | 12'hF00;
      push(r, 1'($urandom_range(0, 1)), a, 8'($urandom), int'($urandom_range(0, 3)), wt);
    end
    drain(4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_apb_sched.md
Name: uart_apb_sched

Overview:
- Two-requester APB master scheduler placed in front of the APB_UART slave port.
- Arbitrates round-robin between requester 0 (TX-side producer: data/config writes) and requester 1 (RX-side consumer: data/status reads).
- Sequences each granted command through the APB SETUP and ACCESS phases and returns completion or read data to the owning requester.
- Aborts with an error response if PREADY never arrives.

Parameters:
- ADDR_W, 12, PADDR width
- WDATA_W, 8, PWDATA / request write-data width
- RDATA_W, 32, PRDATA / response read-data width
- TIMEOUT, 256, ACCESS-phase cycles allowed before abort; legal range 2..65535

Ports:
- PCLK  in  1  single clock
- PRESET  in  1  asynchronous reset, active-high
- req_valid  in  2  per-requester command valid; bit i = requester i
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_W  requester i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*WDATA_W  per-requester write data
- req_ready  out  2  command accepted; one-hot, combinational
- rsp_valid  out  2  one-cycle completion pulse, registered
- rsp_err  out  1  timeout flag for the current response
- rsp_rdata  out  RDATA_W  read data for the current response; 0 for writes and errors
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  WDATA_W  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  RDATA_W  slave read data

Behaviour:
- Reset (async, PRESET=1): immediate and complete.
  - State=IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata all 0.
  - Timeout counter = 0.
  - last_grant=1, so requester 0 wins the first contention.
- Reset mid-transfer: the in-flight command is dropped silently and no rsp_valid is issued. Requesters must reissue.
- States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If exactly one req_valid bit is set, grant it.
  - If both are set, grant the requester != last_grant.
  - req_ready[g]=1 only in IDLE and only for the granted requester, for one cycle.
  - On grant, latch write/addr/wdata, update last_grant=g, go to SETUP.
  - Requesters hold valid and fields stable until ready.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE/PADDR/PWDATA driven from the latch. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address/data held stable; the counter increments each cycle.
  - PREADY=1: capture PRDATA if read, else 0. Set err=0, go to RESP.
  - Counter == TIMEOUT-1 with PREADY=0: set err=1, rdata=0, go to RESP.
  - PREADY wins if it coincides with the timeout cycle.
- RESP (1 cycle):
  - PSEL=PENABLE=0.
  - rsp_valid[g]=1 with rsp_err/rsp_rdata valid.
  - Counter cleared; go to IDLE.
  - rsp_err and rsp_rdata hold their values until the next response.
- Idle bus: PSEL=PENABLE=0. PWRITE/PADDR/PWDATA keep their last values (no glitch-to-zero requirement).
- Latency:
  - Accept at cycle N; SETUP at N+1; first ACCESS at N+2.
  - With zero-wait PREADY, rsp_valid at N+3; next accept at N+4.
  - Each PREADY wait cycle adds 1.
- New requests are never accepted while a transfer is in flight; req_ready=0 in SETUP, ACCESS and RESP.
- A request arriving during RESP is considered in the following IDLE cycle.
- No starvation: under continuous contention grants strictly alternate 0,1,0,1.

Test Plan:
- Single write: req0 write addr 0x004 wdata 0xA5, PREADY tied 1 -> req_ready[0] at N; PSEL=1/PENABLE=0 at N+1; PENABLE=1 with PADDR=0x004, PWDATA=0xA5, PWRITE=1 at N+2; rsp_valid=2'b01, rsp_err=0, rsp_rdata=0 at N+3.
- Wait-state read: req1 read addr 0x004, PREADY low 3 ACCESS cycles then high with PRDATA=0x000000A5 -> ACCESS lasts 4 cycles with PSEL/PENABLE/PADDR stable; rsp_valid=2'b10, rsp_rdata=0x000000A5 at N+6.
- Contention: both valid continuously for 4 transfers from reset -> grant order 0,1,0,1; exactly one req_ready bit per accept; PSEL never high during RESP.
- Timeout (TIMEOUT=8): req0 read, PREADY held 0 -> 8 ACCESS cycles, then PSEL=PENABLE=0; rsp_valid[0]=1, rsp_err=1, rsp_rdata=0; the next request proceeds normally.
- Reset mid-ACCESS: assert PRESET asynchronously during ACCESS -> PSEL/PENABLE go 0 without waiting for a clock edge; no rsp_valid; after release req0 wins a simultaneous request.
- Back-to-back single requester: req0 valid continuously for 3 writes, PREADY=1 -> accepts at N, N+4, N+8; req1 idle and never granted.
